// File: rtl/execute_cycle.sv
// execute_cycle: execute stage of the five-stage RISC-V pipeline.
// Operand forwarding, ALU, BEQ branch resolution, and the execute/memory
// pipeline register, which freezes while the memory stage reports mem_wait.
// Optional feature macro: EXEC_MULDIV_EN. When defined, it builds an
// iterative unsigned MUL/MULHU/DIVU/REMU unit that stalls the front end
// through busy_E. When undefined, MulDivE is ignored and busy_E is always 0.
//
// Handshake: busy_E is a stall request and has no ready counterpart. While
// it is high the hazard unit holds decode, so the E inputs stay stable.
// The M register takes new contents only on edges where mem_wait is low.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic        MulDivE,
  input  logic [1:0]  MulDivOpE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] ResultW,
  input  logic        mem_wait,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        busy_E,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] PCPlus4M,
  output logic [31:0] WriteDataM,
  output logic [31:0] ALU_ResultM,
  output logic [1:0]  o_dbg_state
);

  logic [31:0] w_src_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_result;
  logic        w_zero;

  // Mul/div unit view seen by the M register.
  logic        w_md_done;
  logic [31:0] w_md_result;
  logic        w_md_regwrite;
  logic [4:0]  w_md_rd;

  // Operand forwarding. The select value 11 falls back to the register file.
  always_comb begin
    case (ForwardA_E)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = ALU_ResultM;
      default: w_src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   w_fwd_b = ResultW;
      2'b10:   w_fwd_b = ALU_ResultM;
      default: w_fwd_b = RD2_E;
    endcase
    w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;
  end

  // ALU. Shifts use only the low five bits of SrcB.
  always_comb begin
    w_alu_result = '0;
    case (ALUControlE)
      3'b000:  w_alu_result = w_src_a + w_src_b;
      3'b001:  w_alu_result = w_src_a - w_src_b;
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b100:  w_alu_result = w_src_a ^ w_src_b;
      3'b101:  w_alu_result = {31'b0, ($signed(w_src_a) < $signed(w_src_b))};
      3'b110:  w_alu_result = w_src_a << w_src_b[4:0];
      default: w_alu_result = w_src_a >> w_src_b[4:0];
    endcase
  end

  assign w_zero    = (w_alu_result == 32'd0);
  assign PCTargetE = PCE + Imm_Ext_E;
  // Only BEQ resolves here. A stalled mul/div must never redirect fetch.
  assign PCSrcE    = BranchE & w_zero & ~busy_E;

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  md_state_t   r_state;
  logic [5:0]  r_count;
  logic [1:0]  r_op;
  logic [63:0] r_acc;     // mul: running product; div: {remainder, dividend/quotient}
  logic [63:0] r_mcand;   // mul: multiplicand, shifted left each step
  logic [31:0] r_opb;     // mul: multiplier, shifted right; div: divisor
  logic [31:0] r_result;
  logic        r_md_regwrite;
  logic [4:0]  r_md_rd;

  logic [32:0] w_rem_sh;
  logic        w_rem_ge;
  logic [31:0] w_rem_sub;
  logic [63:0] w_acc_next;

  // One shift-add or restoring-divide step.
  // A divisor of 0 needs no special case. Every trial subtract succeeds,
  // so the quotient becomes all ones and the remainder becomes the dividend.
  always_comb begin
    w_rem_sh  = r_acc[63:31];
    w_rem_ge  = (w_rem_sh >= {1'b0, r_opb});
    // The difference is below the divisor, so it fits in 32 bits.
    w_rem_sub = w_rem_sh[31:0] - r_opb;
    if (r_op[1]) begin
      w_acc_next = w_rem_ge ? {w_rem_sub, r_acc[30:0], 1'b1}
                            : {w_rem_sh[31:0], r_acc[30:0], 1'b0};
    end else begin
      w_acc_next = r_opb[0] ? (r_acc + r_mcand) : r_acc;
    end
  end

  // Mul/div sequencer. RUN takes 32 iteration cycles plus one finalize cycle.
  // DONE waits for the M register to accept the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_op          <= '0;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_opb         <= '0;
      r_result      <= '0;
      r_md_regwrite <= 1'b0;
      r_md_rd       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MulDivE) begin
            r_state       <= S_RUN;
            r_count       <= '0;
            r_op          <= MulDivOpE;
            r_acc         <= MulDivOpE[1] ? {32'b0, w_src_a} : 64'b0;
            r_mcand       <= {32'b0, w_src_a};
            r_opb         <= w_src_b;
            r_md_regwrite <= RegWriteE;
            r_md_rd       <= RD_E;
          end
        end
        S_RUN: begin
          if (r_count == 6'd32) begin
            // The low half holds MUL and DIVU results. The high half holds MULHU and REMU results.
            r_result <= r_op[0] ? r_acc[63:32] : r_acc[31:0];
            r_state  <= S_DONE;
          end else begin
            r_count <= r_count + 6'd1;
            r_acc   <= w_acc_next;
            if (!r_op[1]) begin
              r_mcand <= {r_mcand[62:0], 1'b0};
              r_opb   <= {1'b0, r_opb[31:1]};
            end
          end
        end
        S_DONE: begin
          if (!mem_wait) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_E        = (r_state != S_IDLE) | MulDivE;
  assign w_md_done     = (r_state == S_DONE);
  assign w_md_result   = r_result;
  assign w_md_regwrite = r_md_regwrite;
  assign w_md_rd       = r_md_rd;
  assign o_dbg_state   = r_state;
`else
  logic w_unused_md;
  assign w_unused_md   = ^{MulDivE, MulDivOpE};
  assign busy_E        = 1'b0;
  assign w_md_done     = 1'b0;
  assign w_md_result   = '0;
  assign w_md_regwrite = 1'b0;
  assign w_md_rd       = '0;
  assign o_dbg_state   = 2'b00;
`endif

  // Execute/memory register. It freezes on mem_wait. During a mul/div it
  // loads bubbles, then loads the finished mul/div result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (!mem_wait) begin
      if (w_md_done) begin
        RegWriteM   <= w_md_regwrite;
        MemWriteM   <= 1'b0;
        ResultSrcM  <= 1'b0;
        RD_M        <= w_md_rd;
        ALU_ResultM <= w_md_result;
      end else if (busy_E) begin
        RegWriteM <= 1'b0;
        MemWriteM <= 1'b0;
      end else begin
        RegWriteM   <= RegWriteE;
        MemWriteM   <= MemWriteE;
        ResultSrcM  <= ResultSrcE;
        RD_M        <= RD_E;
        PCPlus4M    <= PCPlus4E;
        WriteDataM  <= w_fwd_b;
        ALU_ResultM <= w_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Testbench for execute_cycle. It applies directed vectors and checks them
// against a behavioural model every cycle, plus literal expectations.
// The mul/div section is built only when EXEC_MULDIV_EN is defined.
module tb_execute_cycle;

`ifdef EXEC_MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteE = 0, MemWriteE = 0, ResultSrcE = 0, BranchE = 0, ALUSrcE = 0;
  logic [2:0]  ALUControlE = '0;
  logic        MulDivE = 0;
  logic [1:0]  MulDivOpE = '0;
  logic [31:0] RD1_E = '0, RD2_E = '0, Imm_Ext_E = '0, PCE = '0, PCPlus4E = '0;
  logic [4:0]  RD_E = '0;
  logic [1:0]  ForwardA_E = '0, ForwardB_E = '0;
  logic [31:0] ResultW = '0;
  logic        mem_wait = 0;
  logic        PCSrcE, busy_E, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [4:0]  RD_M;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .mem_wait(mem_wait),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .busy_E(busy_E),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference rules in plain arithmetic
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rf, input logic [31:0] w, input logic [31:0] m);
    return (s == 2'b01) ? w : (s == 2'b10) ? m : rf;
  endfunction

  // Model of the M register contents and the mul/div occupancy
  logic        exp_rw = 0, exp_mw = 0, exp_rs = 0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_pc4 = '0, exp_wd = '0, exp_alu = '0;
  logic        md_on = 0;
  int          md_edges = 0;
  logic [31:0] md_res = '0;
  logic        md_rw = 0;
  logic [4:0]  md_rd = '0;
  logic [31:0] m_a, m_b, m_sb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_rw = 0; exp_mw = 0; exp_rs = 0; exp_rd = '0;
      exp_pc4 = '0; exp_wd = '0; exp_alu = '0;
      md_on = 0; md_edges = 0;
    end else begin
      m_a  = fwd(ForwardA_E, RD1_E, ResultW, exp_alu);
      m_b  = fwd(ForwardB_E, RD2_E, ResultW, exp_alu);
      m_sb = ALUSrcE ? Imm_Ext_E : m_b;
      if (md_on) begin
        md_edges++;
        if (!mem_wait) begin
          // The result is due 34 edges after the start edge, or later if mem_wait delayed it.
          if (md_edges >= 34) begin
            exp_rw = md_rw; exp_mw = 0; exp_rs = 0; exp_rd = md_rd; exp_alu = md_res;
            md_on = 0;
          end else begin
            exp_rw = 0; exp_mw = 0;
          end
        end
      end else if (MULDIV_ON && MulDivE) begin
        md_on = 1; md_edges = 0;
        md_res = md_ref(MulDivOpE, m_a, m_sb);
        md_rw = RegWriteE; md_rd = RD_E;
        if (!mem_wait) begin exp_rw = 0; exp_mw = 0; end
      end else if (!mem_wait) begin
        exp_rw = RegWriteE; exp_mw = MemWriteE; exp_rs = ResultSrcE; exp_rd = RD_E;
        exp_pc4 = PCPlus4E; exp_wd = m_b; exp_alu = alu_ref(ALUControlE, m_a, m_sb);
      end
    end
  end

  // Per-cycle comparison against the model
  logic [31:0] c_a, c_b, c_sb;
  logic        c_busy, c_br;
  always @(negedge clk) begin
    if (rst) begin
      c_a    = fwd(ForwardA_E, RD1_E, ResultW, exp_alu);
      c_b    = fwd(ForwardB_E, RD2_E, ResultW, exp_alu);
      c_sb   = ALUSrcE ? Imm_Ext_E : c_b;
      c_busy = md_on || (MULDIV_ON && MulDivE);
      c_br   = BranchE && (alu_ref(ALUControlE, c_a, c_sb) == 0) && !c_busy;
      check32("cyc_busy", {31'b0, busy_E}, {31'b0, c_busy});
      check32("cyc_pcsrc", {31'b0, PCSrcE}, {31'b0, c_br});
      check32("cyc_pctarget", PCTargetE, PCE + Imm_Ext_E);
      check32("cyc_regwrite_m", {31'b0, RegWriteM}, {31'b0, exp_rw});
      check32("cyc_memwrite_m", {31'b0, MemWriteM}, {31'b0, exp_mw});
      check32("cyc_resultsrc_m", {31'b0, ResultSrcM}, {31'b0, exp_rs});
      check32("cyc_rd_m", {27'b0, RD_M}, {27'b0, exp_rd});
      check32("cyc_pcplus4_m", PCPlus4M, exp_pc4);
      check32("cyc_writedata_m", WriteDataM, exp_wd);
      check32("cyc_alu_m", ALU_ResultM, exp_alu);
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic set_alu(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, input logic [1:0] fb, input logic src, input logic [31:0] imm);
    ALUControlE = ctl; RD1_E = a; RD2_E = b; ForwardA_E = fa; ForwardB_E = fb;
    ALUSrcE = src; Imm_Ext_E = imm;
    RegWriteE = 1; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; MulDivE = 0; MulDivOpE = '0;
    RD_E = RD_E + 5'd1; PCE = PCE + 32'd4; PCPlus4E = PCE + 32'd4;
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input string nm);
    set_alu(3'd0, a, b, 2'b00, 2'b00, 1'b0, 32'd0);
    MulDivE = 1; MulDivOpE = op; RD_E = 5'd9;
    step(1);
    check32({nm, "_busy"}, {31'b0, busy_E}, 32'd1);
    step(33);
    check32({nm, "_bubble"}, {31'b0, RegWriteM}, 32'd0);
    step(1);
    check32(nm, ALU_ResultM, want);
    check32({nm, "_rd"}, {27'b0, RD_M}, 32'd9);
    check32({nm, "_rw"}, {31'b0, RegWriteM}, 32'd1);
    set_alu(3'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'd0);
    RegWriteE = 0;
  endtask
`endif

  logic [2:0]  t_ctl [10];
  logic [31:0] t_a   [10];
  logic [31:0] t_b   [10];
  logic [1:0]  t_f   [10];
  logic        t_src [10];
  logic [31:0] t_exp [10];

  initial begin
    // Reset
    step(3);
    check32("rst_alu_m", ALU_ResultM, 32'd0);
    check32("rst_rw_m", {31'b0, RegWriteM}, 32'd0);
    check32("rst_rd_m", {27'b0, RD_M}, 32'd0);
    check32("rst_wd_m", WriteDataM, 32'd0);
    check32("rst_busy", {31'b0, busy_E}, 32'd0);
    rst = 1;
    step(1);

    // BEQ taken: 5 - 5 = 0
    set_alu(3'd1, 32'd5, 32'd5, 2'b00, 2'b00, 1'b0, 32'h20);
    BranchE = 1; PCE = 32'h100;
    #1;
    check32("beq_pcsrc", {31'b0, PCSrcE}, 32'd1);
    check32("beq_target", PCTargetE, 32'h120);
    step(1);
    check32("beq_alu_m", ALU_ResultM, 32'd0);

    // BEQ not taken: 5 - 6 != 0
    set_alu(3'd1, 32'd5, 32'd6, 2'b00, 2'b00, 1'b0, 32'h8);
    BranchE = 1;
    #1;
    check32("bne_pcsrc", {31'b0, PCSrcE}, 32'd0);
    step(1);

    // Forwarding: A from ALU_ResultM (0x10), B from ResultW (0x3)
    set_alu(3'd0, 32'h10, 32'd0, 2'b00, 2'b00, 1'b0, 32'd0);
    step(1);
    set_alu(3'd0, 32'hDEAD, 32'hBEEF, 2'b10, 2'b01, 1'b0, 32'd0);
    ResultW = 32'h3; MemWriteE = 1;
    step(1);
    check32("fwd_alu_m", ALU_ResultM, 32'h13);
    check32("fwd_wd_m", WriteDataM, 32'h3);
    check32("fwd_mw_m", {31'b0, MemWriteM}, 32'd1);

    // ALU operation table
    t_ctl[0] = 3'd2; t_a[0] = 32'hF0F0_FFFF; t_b[0] = 32'h0FF0_00FF; t_f[0] = 2'b00; t_src[0] = 0; t_exp[0] = 32'h00F0_00FF;
    t_ctl[1] = 3'd3; t_a[1] = 32'hF000_0000; t_b[1] = 32'h0000_000F; t_f[1] = 2'b00; t_src[1] = 0; t_exp[1] = 32'hF000_000F;
    t_ctl[2] = 3'd4; t_a[2] = 32'hFFFF_0000; t_b[2] = 32'h0F0F_0F0F; t_f[2] = 2'b00; t_src[2] = 0; t_exp[2] = 32'hF0F0_0F0F;
    t_ctl[3] = 3'd5; t_a[3] = 32'hFFFF_FFFF; t_b[3] = 32'd1;         t_f[3] = 2'b00; t_src[3] = 0; t_exp[3] = 32'd1;
    t_ctl[4] = 3'd5; t_a[4] = 32'd1;         t_b[4] = 32'hFFFF_FFFF; t_f[4] = 2'b00; t_src[4] = 0; t_exp[4] = 32'd0;
    t_ctl[5] = 3'd6; t_a[5] = 32'd1;         t_b[5] = 32'd31;        t_f[5] = 2'b00; t_src[5] = 0; t_exp[5] = 32'h8000_0000;
    t_ctl[6] = 3'd6; t_a[6] = 32'd1;         t_b[6] = 32'h21;        t_f[6] = 2'b00; t_src[6] = 0; t_exp[6] = 32'd2;
    t_ctl[7] = 3'd7; t_a[7] = 32'h8000_0000; t_b[7] = 32'd4;         t_f[7] = 2'b00; t_src[7] = 0; t_exp[7] = 32'h0800_0000;
    t_ctl[8] = 3'd1; t_a[8] = 32'd3;         t_b[8] = 32'd5;         t_f[8] = 2'b00; t_src[8] = 0; t_exp[8] = 32'hFFFF_FFFE;
    t_ctl[9] = 3'd0; t_a[9] = 32'h40;        t_b[9] = 32'd2;         t_f[9] = 2'b11; t_src[9] = 0; t_exp[9] = 32'h42;
    for (int i = 0; i < 10; i++) begin
      set_alu(t_ctl[i], t_a[i], t_b[i], t_f[i], t_f[i], t_src[i], 32'h5555_0000);
      step(1);
      check32($sformatf("alu_tbl_%0d", i), ALU_ResultM, t_exp[i]);
    end

    // Immediate operand replaces B
    set_alu(3'd0, 32'h100, 32'hFFFF, 2'b00, 2'b00, 1'b1, 32'h23);
    step(1);
    check32("imm_alu_m", ALU_ResultM, 32'h123);
    check32("imm_wd_m", WriteDataM, 32'hFFFF);

    // mem_wait freezes the M register
    set_alu(3'd0, 32'd1, 32'd1, 2'b00, 2'b00, 1'b0, 32'd0);
    mem_wait = 1;
    step(2);
    check32("freeze_alu_m", ALU_ResultM, 32'h123);
    mem_wait = 0;
    step(1);
    check32("unfreeze_alu_m", ALU_ResultM, 32'd2);

`ifdef EXEC_MULDIV_EN
    run_md(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul");
    run_md(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, "mulhu");
    run_md(2'b10, 32'd7, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    run_md(2'b11, 32'd7, 32'd0, 32'd7, "remu_by0");
    run_md(2'b10, 32'd100, 32'd7, 32'd14, "divu");
    run_md(2'b11, 32'd100, 32'd7, 32'd2, "remu");

    // mem_wait held high across DONE. The result lands on the first free edge.
    set_alu(3'd0, 32'd3, 32'd5, 2'b00, 2'b00, 1'b0, 32'd0);
    MulDivE = 1; MulDivOpE = 2'b00; RD_E = 5'd9;
    step(31);
    mem_wait = 1;
    step(5);
    check32("mw_hold_alu_m", ALU_ResultM, 32'd2);
    check32("mw_hold_busy", {31'b0, busy_E}, 32'd1);
    mem_wait = 0;
    step(1);
    check32("mw_mul_alu_m", ALU_ResultM, 32'd15);
    set_alu(3'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'd0);
    RegWriteE = 0;
    step(1);

    // Reset in the middle of a multiply leaves no result
    set_alu(3'd0, 32'd7, 32'd6, 2'b00, 2'b00, 1'b0, 32'd0);
    MulDivE = 1;
    step(10);
    rst = 0; MulDivE = 0;
    #1;
    check32("midrst_alu_m", ALU_ResultM, 32'd0);
    check32("midrst_busy", {31'b0, busy_E}, 32'd0);
    step(2);
    rst = 1;
    set_alu(3'd0, 32'd1, 32'd1, 2'b00, 2'b00, 1'b0, 32'd0);
    step(40);
    check32("midrst_after_alu_m", ALU_ResultM, 32'd2);
`else
    // Without the unit, MulDivE is ignored and the ALU op executes
    set_alu(3'd0, 32'd3, 32'd4, 2'b00, 2'b00, 1'b0, 32'd0);
    MulDivE = 1; MulDivOpE = 2'b00;
    #1;
    check32("nomd_busy", {31'b0, busy_E}, 32'd0);
    step(1);
    check32("nomd_alu_m", ALU_ResultM, 32'd7);
    MulDivE = 0;
    step(1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
